// File: rtl/pipeline_hs.sv
// pipeline_hs: 3-stage valid/ready pipeline computing F = (A+B+C-D)*D with a tag.
// Optional PIPELINE_HS_SAT_EN clamps F to [0, 2^N-1] and adds the f_sat flag.
module pipeline_hs #(
  parameter int N = 10,
  parameter int TAG_W = 4,
  localparam int OW = 2*N+3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     c,
  input  logic [N-1:0]     d,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    f,
  output logic [TAG_W-1:0] out_tag,
`ifdef PIPELINE_HS_SAT_EN
  output logic             f_sat,
`endif
  output logic             busy
);

  typedef struct packed {
    logic [N:0]       p;
    logic [N+1:0]     q;
    logic [N-1:0]     d;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [N+2:0]     s;
    logic [N-1:0]     d;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic v1, v2, v3;
  logic r1, r2, r3;
  s1_t  s1, s1_n;
  s2_t  s2, s2_n;

  logic [OW-1:0] s_ext;
  logic [OW-1:0] d_ext;
  logic [OW-1:0] prod;
  logic [OW-1:0] f_n;

  assign r3 = !v3 | out_ready;
  assign r2 = !v2 | r3;
  assign r1 = !v1 | r2;

  assign in_ready  = r1;
  assign out_valid = v3;
  assign busy      = v1 | v2 | v3;

  always_comb begin
    s1_n.p   = {1'b0, a} + {1'b0, b};
    s1_n.q   = {2'b00, c} - {2'b00, d};
    s1_n.d   = d;
    s1_n.tag = in_tag;
  end

  // q is signed: sign-extend it, zero-extend the unsigned p
  always_comb begin
    s2_n.s   = {2'b00, s1.p} + {s1.q[N+1], s1.q};
    s2_n.d   = s1.d;
    s2_n.tag = s1.tag;
  end

  // Product range fits OW signed bits, so an OW-wide multiply is exact
  assign s_ext = {{N{s2.s[N+2]}}, s2.s};
  assign d_ext = {{(OW-N){1'b0}}, s2.d};
  assign prod  = OW'($signed(s_ext) * $signed(d_ext));

`ifdef PIPELINE_HS_SAT_EN
  logic sat_n;

  always_comb begin
    f_n   = prod;
    sat_n = 1'b0;
    if (prod[OW-1]) begin
      f_n   = '0;
      sat_n = 1'b1;
    end else if (|prod[OW-2:N]) begin
      f_n   = {{(OW-N){1'b0}}, {N{1'b1}}};
      sat_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_sat <= 1'b0;
    end else if (r3 && v2) begin
      f_sat <= sat_n;
    end
  end
`else
  assign f_n = prod;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (r1) begin
      v1 <= in_valid;
      if (in_valid) s1 <= s1_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      s2 <= '0;
    end else if (r2) begin
      v2 <= v1;
      if (v1) s2 <= s2_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3      <= 1'b0;
      f       <= '0;
      out_tag <= '0;
    end else if (r3) begin
      v3 <= v2;
      if (v2) begin
        f       <= f_n;
        out_tag <= s2.tag;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hs.sv
// tb_pipeline_hs: scoreboard bench for pipeline_hs.
// Stimulus queues expected results; a negedge monitor pops on output handshakes.
`timescale 1ns/1ps
module tb_pipeline_hs;
  localparam int N  = 10;
  localparam int TW = 4;
  localparam int OW = 2*N+3;

  typedef struct {
    logic [OW-1:0] ef;
    logic [OW-1:0] sf;
    logic          ss;
    logic [TW-1:0] tag;
    int            cyc;
    bit            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic [N-1:0]  c = '0;
  logic [N-1:0]  d = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] f;
  logic [TW-1:0] out_tag;
  logic          busy;
`ifdef PIPELINE_HS_SAT_EN
  logic          f_sat;
`endif

  exp_t          sb[$];
  exp_t          me;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            hold = 0;
  bit            done = 0;
  logic [OW-1:0] hf;
  logic [TW-1:0] ht;

  pipeline_hs #(.N(N), .TAG_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .c(c),
    .d(d),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f(f),
    .out_tag(out_tag),
`ifdef PIPELINE_HS_SAT_EN
    .f_sat(f_sat),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: stall stability and in-order scoreboard compare
  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("stall_valid", longint'(out_valid), 1);
        chk("stall_f", longint'(f), longint'(hf));
        chk("stall_tag", longint'(out_tag), longint'(ht));
      end
      hold = out_valid && !out_ready;
      hf = f;
      ht = out_tag;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=tag%0d required=none",
                   out_tag);
        end else begin
          me = sb.pop_front();
`ifdef PIPELINE_HS_SAT_EN
          chk("out_f", longint'(f), longint'(me.sf));
          chk("out_sat", longint'(f_sat), longint'(me.ss));
`else
          chk("out_f", longint'(f), longint'(me.ef));
`endif
          chk("out_tag", longint'(out_tag), longint'(me.tag));
          if (me.lat) chk("latency", longint'(cyc - me.cyc), 3);
        end
      end
    end
  end

  function automatic longint model(int ta, int tb_, int tc, int td);
    longint la = ta;
    longint lb = tb_;
    longint lc = tc;
    longint ld = td;
    return (la + lb + lc - ld) * ld;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the handshake
  task automatic send(int ta, int tb_, int tc, int td, int tt,
                      int ef, int sf, int ss, int lat);
    exp_t e;
    int w = 0;
    a = N'(ta);
    b = N'(tb_);
    c = N'(tc);
    d = N'(td);
    in_tag = TW'(tt);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready0 required=in_ready1");
    end else begin
      e.ef = OW'(ef);
      e.sf = OW'(sf);
      e.ss = (ss != 0);
      e.tag = TW'(tt);
      e.cyc = cyc;
      e.lat = (lat != 0);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(int tt);
    int ra = int'($urandom_range(0, (1 << N) - 1));
    int rb = int'($urandom_range(0, (1 << N) - 1));
    int rc = int'($urandom_range(0, (1 << N) - 1));
    int rd = int'($urandom_range(0, (1 << N) - 1));
    longint ex = model(ra, rb, rc, rd);
    int sf = int'(ex);
    int ss = 0;
    if (ex < 0) begin
      sf = 0;
      ss = 1;
    end else if (ex > (1 << N) - 1) begin
      sf = (1 << N) - 1;
      ss = 1;
    end
    send(ra, rb, rc, rd, tt, int'(ex), sf, ss, 0);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 400) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
    @(negedge clk);
    chk("drained_busy", longint'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_f", longint'(f), 0);
    chk("rst_out_tag", longint'(out_tag), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(1, 2, 3, 4, 1, 8, 8, 0, 1);
    send(0, 3, 5, 2, 2, 12, 12, 0, 1);
    send(1, 0, 1, 1, 3, 1, 1, 0, 1);
    send(2, 2, 2, 2, 4, 8, 8, 0, 1);
    send(0, 0, 0, 5, 5, -25, 0, 1, 1);
    send(1023, 1023, 1023, 1023, 6, 2093058, 1023, 1, 1);
    drain();

    out_ready = 1'b0;
    send(1, 1, 1, 1, 7, 2, 2, 0, 0);
    send(2, 3, 4, 5, 8, 20, 20, 0, 0);
    send(3, 3, 3, 3, 9, 18, 18, 0, 0);
    @(negedge clk);
    chk("full_in_ready", longint'(in_ready), 0);
    chk("full_busy", longint'(busy), 1);
    chk("full_out_valid", longint'(out_valid), 1);
    @(posedge clk);
    #1;
    fork
      begin
        send(10, 0, 0, 1, 10, 9, 9, 0, 0);
        send(0, 0, 7, 3, 11, 12, 12, 0, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_rand(i % 16);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b1;
    send(4, 4, 4, 4, 12, 32, 32, 0, 0);
    send(5, 5, 5, 5, 13, 50, 50, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_in_ready", longint'(in_ready), 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("postrst_busy", longint'(busy), 0);
    chk("postrst_out_valid", longint'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
